mem_stack_unit: RTL and testbench
=================================

# mem_stack_unit

Memory-stage stack and data-access unit. It consumes the control unit's memory-side outputs (stack, MemR, MemWR, mem_data_sel, pop_pc1/pop_pc2/pop_ccr) as carried by the EX/MEM pipeline register. It owns the stack pointer and drives the synchronous data memory, selecting between the source register, the two PC halves and the CCR. On pops it reassembles the returned PC and CCR and hands them back to fetch and the flag register.

## Interface
Parameters:
- ADDR_W, 12, data-memory word-address width
- DATA_W, 16, memory word width
- PC_W, 32, PC width; must equal 2*DATA_W
- SP_INIT, 2**ADDR_W-1, stack pointer value after reset (empty stack)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- stack  in  1  access uses SP instead of alu_addr
- mem_rd  in  1  read request (MemR)
- mem_wr  in  1  write request (MemWR)
- mem_data_sel  in  2  write source: 00 reg_data, 01 pc[31:16], 10 pc[15:0], 11 {13'b0, ccr}
- pop_pc1, pop_pc2, pop_ccr  in  1 each  tag the current stack read
- alu_addr  in  ADDR_W  non-stack address
- reg_data  in  DATA_W  store data
- pc  in  PC_W  PC to push
- ccr  in  3  flags to push
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_re
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we, mem_re  out  1  memory strobes
- load_data  out  DATA_W  untagged read result
- load_valid  out  1  load_data valid
- pc_restore  out  PC_W  reassembled return PC
- pc_restore_valid  out  1  one-cycle pulse
- ccr_restore  out  3  popped flags
- ccr_restore_valid  out  1  one-cycle pulse
- sp  out  ADDR_W  current stack pointer
- stack_overflow, stack_underflow, access_error  out  1  sticky error flags

## Operation
- The stack grows down. SP points to the next free word.
- Push (stack & mem_wr): write at SP, then SP←SP-1.
- Pop (stack & mem_rd): read at SP+1, then SP←SP+1.
- Non-stack access uses alu_addr. SP is unchanged.
- Push order for CALL/INT: pc high half (sel 01), pc low half (sel 10), CCR (sel 11). Pop order is the reverse: pop_ccr, pop_pc2 (low half), pop_pc1 (high half).
- Read-tag register: {pop_pc1, pop_pc2, pop_ccr, plain} is captured with each read and applied to mem_rdata next cycle.
  - plain → load_data/load_valid
  - pop_ccr → ccr_restore = mem_rdata[2:0]
  - pop_pc2 → lo_hold ← mem_rdata, half_pending ← 1
  - pop_pc1 with half_pending → pc_restore = {mem_rdata, lo_hold}, pulse valid, clear half_pending
- Boundary and error cases:
  - Push with SP==0: write suppressed, SP held, stack_overflow set.
  - Pop with SP==SP_INIT: read suppressed, SP held, stack_underflow set, no valid pulse.
  - mem_rd & mem_wr together: no access, SP held, access_error set.
  - pop_pc1 without half_pending: access_error set, no pc_restore_valid.
  - More than one pop_* tag together: access_error set, read performed, result discarded.
  - pop_* without stack & mem_rd: ignored.
- Reset (rst=0 at an edge): SP=SP_INIT, half_pending=0, lo_hold=0, tag register cleared, all valid pulses and error flags 0.
  - Reset mid-restore drops the partial PC.
  - mem_addr, mem_wdata, mem_we and mem_re are combinational from inputs and SP. While rst=0 they are forced to 0.

## Timing
- Cycle N: request present. mem_addr, mem_we, mem_re and mem_wdata are driven combinationally. SP updates at the end of N.
- Cycle N+1: mem_rdata valid. load_valid, ccr_restore_valid and pc_restore_valid are asserted combinationally from the tag register and mem_rdata, for one cycle.
- RET sequence: pop_pc2 at N, pop_pc1 at N+1, pc_restore_valid at N+2.
- RTI sequence: pop_ccr at N, pop_pc2 at N+1, pop_pc1 at N+2, ccr_restore_valid at N+1, pc_restore_valid at N+3.
- Back-to-back pushes and pops are supported, one per cycle. Push then pop in consecutive cycles returns the just-written word.

## Structure
- Shared package holds:
  - mem_data_sel encodings (SEL_REG, SEL_PC_HI, SEL_PC_LO, SEL_CCR)
  - the read-tag typedef
  - the DATA_W/PC_W constants also used by the control unit
- One natural sub-module, stack_pointer: SP register, full/empty detection, next-SP logic. Everything else stays in mem_stack_unit.

## Test plan
- Reset then idle: sp=0xFFF, all strobes and valids 0, error flags 0.
- Push reg_data=0x1234 → mem_we=1, mem_addr=0xFFF, mem_wdata=0x1234; sp=0xFFE next cycle. Pop next cycle → mem_addr=0xFFF; load_data=0x1234 with load_valid one cycle later.
- CALL with pc=0xABCD0042: pushes 0xABCD@0xFFF and 0x0042@0xFFE. RET (pop_pc2 then pop_pc1) → pc_restore=0xABCD0042, pc_restore_valid exactly 2 cycles after pop_pc2; sp back to 0xFFF.
- INT with pc=0x00010020, ccr=3'b101, then RTI → ccr_restore=3'b101 at pop+1, pc_restore=0x00010020 at pop_ccr+3.
- Pop at sp=0xFFF → no mem_re, stack_underflow=1, sp unchanged. mem_rd & mem_wr together → access_error=1, no strobes.
- rst=0 between pop_pc2 and pop_pc1 → no pc_restore_valid. A following lone pop_pc1 sets access_error.

Source files
------------

// File: rtl/mem_stack_unit_pkg.sv
// Shared memory-stage definitions: store-source encodings, read-tag layout and
// the datapath widths the control unit also relies on.
package mem_stack_unit_pkg;

    localparam int unsigned MEM_DATA_W = 16;
    localparam int unsigned MEM_PC_W   = 2 * MEM_DATA_W;
    localparam int unsigned CCR_W      = 3;

    typedef enum logic [1:0] {
        SEL_REG   = 2'b00,
        SEL_PC_HI = 2'b01,
        SEL_PC_LO = 2'b10,
        SEL_CCR   = 2'b11
    } mem_sel_e;

    // Attached to every performed read, consumed when mem_rdata returns.
    typedef struct packed {
        logic pop_pc1;
        logic pop_pc2;
        logic pop_ccr;
        logic plain;
    } read_tag_t;

endpackage

// File: rtl/mem_stack_unit_stack_pointer.sv
// Downward-growing stack pointer: SP addresses the next free word, so a pop
// reads SP+1.
module stack_pointer #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned SP_INIT = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_inc,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W-1:0] SP_RST = ADDR_W'(SP_INIT);

    assign sp_inc = sp + ADDR_W'(1);
    assign full   = (sp == '0);
    assign empty  = (sp == SP_RST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp <= SP_RST;
        end else if (push) begin
            sp <= sp - ADDR_W'(1);
        end else if (pop) begin
            sp <= sp_inc;
        end
    end

endmodule

// File: rtl/mem_stack_unit.sv
// Memory-stage stack and data-access unit: drives the synchronous data memory
// and reassembles popped PC/CCR values for fetch and the flag register.
module mem_stack_unit
    import mem_stack_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = MEM_DATA_W,
    parameter int unsigned PC_W    = MEM_PC_W,
    parameter int unsigned SP_INIT = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stack,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [1:0]        mem_data_sel,
    input  logic              pop_pc1,
    input  logic              pop_pc2,
    input  logic              pop_ccr,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [PC_W-1:0]   pc,
    input  logic [2:0]        ccr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic [PC_W-1:0]   pc_restore,
    output logic              pc_restore_valid,
    output logic [2:0]        ccr_restore,
    output logic              ccr_restore_valid,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_overflow,
    output logic              stack_underflow,
    output logic              access_error
);

    logic [ADDR_W-1:0] sp_inc;
    logic              sp_full;
    logic              sp_empty;
    logic              clash;
    logic              push_req;
    logic              pop_req;
    logic              push_ok;
    logic              pop_ok;
    logic              plain_wr;
    logic              plain_rd;
    logic              multi_tag;
    logic              half_pending;
    logic [DATA_W-1:0] lo_hold;
    logic [DATA_W-1:0] wr_src;
    read_tag_t         tag_d;
    read_tag_t         tag_q;

    assign clash     = mem_rd & mem_wr;
    assign push_req  = stack & mem_wr & ~mem_rd;
    assign pop_req   = stack & mem_rd & ~mem_wr;
    assign push_ok   = push_req & ~sp_full;
    assign pop_ok    = pop_req & ~sp_empty;
    assign plain_wr  = ~stack & mem_wr & ~mem_rd;
    assign plain_rd  = ~stack & mem_rd & ~mem_wr;
    assign multi_tag = (pop_pc1 & pop_pc2) | (pop_pc1 & pop_ccr) | (pop_pc2 & pop_ccr);

    stack_pointer #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_stack_pointer (
        .clk    (clk),
        .rst    (rst),
        .push   (push_ok),
        .pop    (pop_ok),
        .sp     (sp),
        .sp_inc (sp_inc),
        .full   (sp_full),
        .empty  (sp_empty)
    );

    always_comb begin
        wr_src = reg_data;
        case (mem_sel_e'(mem_data_sel))
            SEL_PC_HI: wr_src = pc[PC_W-1 -: DATA_W];
            SEL_PC_LO: wr_src = pc[DATA_W-1:0];
            SEL_CCR:   wr_src = {{(DATA_W-3){1'b0}}, ccr};
            default:   wr_src = reg_data;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst) begin
            mem_we    = push_ok | plain_wr;
            mem_re    = pop_ok | plain_rd;
            mem_addr  = stack ? (pop_req ? sp_inc : sp) : alu_addr;
            mem_wdata = wr_src;
        end
    end

    // A multi-tagged pop still reads but carries an empty tag so nothing is delivered.
    always_comb begin
        tag_d = '0;
        if (pop_ok && !multi_tag) begin
            tag_d.pop_pc1 = pop_pc1;
            tag_d.pop_pc2 = pop_pc2;
            tag_d.pop_ccr = pop_ccr;
            tag_d.plain   = ~(pop_pc1 | pop_pc2 | pop_ccr);
        end else if (plain_rd) begin
            tag_d.plain = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q           <= '0;
            half_pending    <= 1'b0;
            lo_hold         <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            access_error    <= 1'b0;
        end else begin
            tag_q <= tag_d;
            if (tag_q.pop_pc2) begin
                lo_hold      <= mem_rdata;
                half_pending <= 1'b1;
            end else if (tag_q.pop_pc1) begin
                half_pending <= 1'b0;
            end
            if (push_req && sp_full) begin
                stack_overflow <= 1'b1;
            end
            if (pop_req && sp_empty) begin
                stack_underflow <= 1'b1;
            end
            if (clash || (pop_ok && multi_tag) || (tag_q.pop_pc1 && !half_pending)) begin
                access_error <= 1'b1;
            end
        end
    end

    assign load_data         = mem_rdata;
    assign load_valid        = tag_q.plain;
    assign ccr_restore       = mem_rdata[2:0];
    assign ccr_restore_valid = tag_q.pop_ccr;
    assign pc_restore        = {mem_rdata, lo_hold};
    assign pc_restore_valid  = tag_q.pop_pc1 & half_pending;

endmodule

// File: tb/tb_mem_stack_unit.sv
// Randomised and directed bench for mem_stack_unit against a queue-based model
// of the stack and a word array for plain data accesses.
module tb_mem_stack_unit;

    localparam int unsigned AW  = 12;
    localparam int unsigned DW  = 16;
    localparam int unsigned PW  = 32;
    localparam int unsigned TOP = 4095;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stack = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
    logic [1:0]    mem_data_sel = '0;
    logic          pop_pc1 = 1'b0, pop_pc2 = 1'b0, pop_ccr = 1'b0;
    logic [AW-1:0] alu_addr = '0;
    logic [DW-1:0] reg_data = '0;
    logic [PW-1:0] pc = '0;
    logic [2:0]    ccr = '0;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we, mem_re;
    logic [DW-1:0] load_data;
    logic          load_valid;
    logic [PW-1:0] pc_restore;
    logic          pc_restore_valid;
    logic [2:0]    ccr_restore;
    logic          ccr_restore_valid;
    logic [AW-1:0] sp;
    logic          stack_overflow, stack_underflow, access_error;

    always #5 clk = ~clk;

    mem_stack_unit #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .PC_W    (PW),
        .SP_INIT (TOP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stack             (stack),
        .mem_rd            (mem_rd),
        .mem_wr            (mem_wr),
        .mem_data_sel      (mem_data_sel),
        .pop_pc1           (pop_pc1),
        .pop_pc2           (pop_pc2),
        .pop_ccr           (pop_ccr),
        .alu_addr          (alu_addr),
        .reg_data          (reg_data),
        .pc                (pc),
        .ccr               (ccr),
        .mem_rdata         (mem_rdata),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_we            (mem_we),
        .mem_re            (mem_re),
        .load_data         (load_data),
        .load_valid        (load_valid),
        .pc_restore        (pc_restore),
        .pc_restore_valid  (pc_restore_valid),
        .ccr_restore       (ccr_restore),
        .ccr_restore_valid (ccr_restore_valid),
        .sp                (sp),
        .stack_overflow    (stack_overflow),
        .stack_underflow   (stack_underflow),
        .access_error      (access_error)
    );

    // Synchronous data memory seen by the DUT.
    logic [DW-1:0] phys [0:4095];
    always @(posedge clk) begin
        if (mem_we) phys[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= phys[mem_addr];
    end

    typedef struct {
        logic          stk, rd, wr;
        logic [1:0]    sel;
        logic          t1, t2, tc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [PW-1:0] pcv;
        logic [2:0]    ccrv;
    } op_t;

    typedef enum int {K_NONE, K_PLAIN, K_CCR, K_LO, K_HI} kind_e;

    // Reference model: stack contents as a queue (top = back), plain words 0..15.
    logic [DW-1:0] stk_q[$];
    logic [DW-1:0] ref_mem [0:15];
    kind_e         st_kind = K_NONE;
    logic [DW-1:0] st_word = '0;
    bit            have_lo = 1'b0;
    logic [DW-1:0] lo_word = '0;
    bit            e_ovf = 1'b0, e_unf = 1'b0, e_aerr = 1'b0;
    int unsigned   n_checks = 0;
    int unsigned   n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] src_word(input op_t o);
        case (o.sel)
            2'b01:   return o.pcv[31:16];
            2'b10:   return o.pcv[15:0];
            2'b11:   return {13'b0, o.ccrv};
            default: return o.data;
        endcase
    endfunction

    function automatic op_t f_idle();
        op_t o;
        o = '{default: '0};
        return o;
    endfunction

    function automatic op_t f_push(input logic [1:0] s, input logic [DW-1:0] d,
                                   input logic [PW-1:0] p, input logic [2:0] c);
        op_t o = f_idle();
        o.stk = 1'b1; o.wr = 1'b1; o.sel = s; o.data = d; o.pcv = p; o.ccrv = c;
        return o;
    endfunction

    function automatic op_t f_pop(input logic t1, input logic t2, input logic tc);
        op_t o = f_idle();
        o.stk = 1'b1; o.rd = 1'b1; o.t1 = t1; o.t2 = t2; o.tc = tc;
        return o;
    endfunction

    function automatic op_t f_st(input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o = f_idle();
        o.wr = 1'b1; o.addr = a; o.data = d;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o = f_idle();
        int unsigned r = $urandom_range(0, 99);
        int unsigned t = $urandom_range(0, 9);
        o.sel  = 2'($urandom);
        o.data = 16'($urandom);
        o.pcv  = $urandom;
        o.ccrv = 3'($urandom);
        o.addr = 12'($urandom_range(0, 15));
        if (r < 35) begin
            o.stk = 1'b1; o.wr = 1'b1;
        end else if (r < 70) begin
            o.stk = 1'b1; o.rd = 1'b1;
            o.tc = (t == 3 || t == 4);
            o.t2 = (t == 5 || t == 6 || t == 9);
            o.t1 = (t == 7 || t == 8 || t == 9);
        end else if (r < 80) begin
            o.wr = 1'b1;
        end else if (r < 90) begin
            o.rd = 1'b1;
            o.t1 = 1'($urandom); o.t2 = 1'($urandom); o.tc = 1'($urandom);
        end else if (r < 95) begin
            o.stk = 1'($urandom); o.rd = 1'b1; o.wr = 1'b1;
        end
        return o;
    endfunction

    // One clock cycle: drive, check last read's delivery and this request, advance model.
    task automatic run_op(input op_t o);
        logic [DW-1:0] w, nw;
        logic [AW-1:0] ea;
        bit            ewe, ere;
        kind_e         nk;
        int unsigned   ntag, depth;
        @(negedge clk);
        rst = 1'b1;
        stack = o.stk; mem_rd = o.rd; mem_wr = o.wr; mem_data_sel = o.sel;
        pop_pc1 = o.t1; pop_pc2 = o.t2; pop_ccr = o.tc;
        alu_addr = o.addr; reg_data = o.data; pc = o.pcv; ccr = o.ccrv;
        #1;
        depth = stk_q.size();
        check_eq("sp", 32'(sp), 32'(TOP - depth));
        check_eq("overflow", 32'(stack_overflow), 32'(e_ovf));
        check_eq("underflow", 32'(stack_underflow), 32'(e_unf));
        check_eq("access_error", 32'(access_error), 32'(e_aerr));
        check_eq("load_valid", 32'(load_valid), 32'(st_kind == K_PLAIN));
        if (st_kind == K_PLAIN) check_eq("load_data", 32'(load_data), 32'(st_word));
        check_eq("ccr_valid", 32'(ccr_restore_valid), 32'(st_kind == K_CCR));
        if (st_kind == K_CCR) check_eq("ccr_restore", 32'(ccr_restore), 32'(st_word[2:0]));
        check_eq("pc_valid", 32'(pc_restore_valid), 32'(st_kind == K_HI && have_lo));
        if (st_kind == K_HI && have_lo) check_eq("pc_restore", pc_restore, {st_word, lo_word});
        if (st_kind == K_LO) begin
            have_lo = 1'b1;
            lo_word = st_word;
        end else if (st_kind == K_HI) begin
            if (have_lo) have_lo = 1'b0;
            else e_aerr = 1'b1;
        end

        w = src_word(o); nw = '0; ea = '0; ewe = 1'b0; ere = 1'b0; nk = K_NONE;
        ntag = int'(o.t1) + int'(o.t2) + int'(o.tc);
        if (o.rd && o.wr) begin
            e_aerr = 1'b1;
        end else if (o.wr && o.stk) begin
            if (depth == TOP) e_ovf = 1'b1;
            else begin
                ewe = 1'b1; ea = 12'(TOP - depth); stk_q.push_back(w);
            end
        end else if (o.rd && o.stk) begin
            if (depth == 0) e_unf = 1'b1;
            else begin
                ere = 1'b1; ea = 12'(TOP - depth + 1); nw = stk_q.pop_back();
                if (ntag > 1) e_aerr = 1'b1;
                else if (o.tc) nk = K_CCR;
                else if (o.t2) nk = K_LO;
                else if (o.t1) nk = K_HI;
                else nk = K_PLAIN;
            end
        end else if (o.wr) begin
            ewe = 1'b1; ea = o.addr; ref_mem[o.addr[3:0]] = w;
        end else if (o.rd) begin
            ere = 1'b1; ea = o.addr; nk = K_PLAIN; nw = ref_mem[o.addr[3:0]];
        end
        check_eq("mem_we", 32'(mem_we), 32'(ewe));
        check_eq("mem_re", 32'(mem_re), 32'(ere));
        if (ewe || ere) check_eq("mem_addr", 32'(mem_addr), 32'(ea));
        if (ewe) check_eq("mem_wdata", 32'(mem_wdata), 32'(w));
        st_kind = nk;
        st_word = nw;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; stack = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0; mem_data_sel = 2'b00;
        reg_data = 16'hBEEF; alu_addr = 12'h005;
        #1;
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_re", 32'(mem_re), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
        @(posedge clk);
        stk_q.delete();
        have_lo = 1'b0; st_kind = K_NONE;
        e_ovf = 1'b0; e_unf = 1'b0; e_aerr = 1'b0;
    endtask

    initial begin
        do_reset();
        run_op(f_idle());
        check_eq("idle_sp", 32'(sp), 32'h0FFF);

        // Plain push then pop of reg_data.
        run_op(f_push(2'b00, 16'h1234, '0, '0));
        run_op(f_pop(1'b0, 1'b0, 1'b0));
        #1;
        check_eq("pop_load_valid", 32'(load_valid), 32'd1);
        check_eq("pop_load_data", 32'(load_data), 32'h1234);

        // CALL / RET.
        run_op(f_push(2'b01, '0, 32'hABCD0042, '0));
        run_op(f_push(2'b10, '0, 32'hABCD0042, '0));
        run_op(f_pop(1'b0, 1'b1, 1'b0));
        run_op(f_pop(1'b1, 1'b0, 1'b0));
        #1;
        check_eq("ret_valid", 32'(pc_restore_valid), 32'd1);
        check_eq("ret_pc", pc_restore, 32'hABCD0042);
        check_eq("ret_sp", 32'(sp), 32'h0FFF);

        // INT / RTI.
        run_op(f_push(2'b01, '0, 32'h00010020, 3'b101));
        run_op(f_push(2'b10, '0, 32'h00010020, 3'b101));
        run_op(f_push(2'b11, '0, 32'h00010020, 3'b101));
        run_op(f_pop(1'b0, 1'b0, 1'b1));
        #1;
        check_eq("rti_ccr_valid", 32'(ccr_restore_valid), 32'd1);
        check_eq("rti_ccr", 32'(ccr_restore), 32'h5);
        run_op(f_pop(1'b0, 1'b1, 1'b0));
        run_op(f_pop(1'b1, 1'b0, 1'b0));
        #1;
        check_eq("rti_pc_valid", 32'(pc_restore_valid), 32'd1);
        check_eq("rti_pc", pc_restore, 32'h00010020);

        // Underflow and read/write clash.
        run_op(f_pop(1'b0, 1'b0, 1'b0));
        #1;
        check_eq("unf_flag", 32'(stack_underflow), 32'd1);
        check_eq("unf_sp", 32'(sp), 32'h0FFF);
        run_op('{stk: 1'b1, rd: 1'b1, wr: 1'b1, sel: 2'b00, t1: 1'b0, t2: 1'b0, tc: 1'b0,
                 addr: 12'h0, data: 16'h55AA, pcv: '0, ccrv: '0});
        #1;
        check_eq("clash_flag", 32'(access_error), 32'd1);
        run_op(f_idle());

        // Reset between the two halves of a RET drops the partial PC.
        do_reset();
        run_op(f_push(2'b01, '0, 32'h12345678, '0));
        run_op(f_push(2'b10, '0, 32'h12345678, '0));
        run_op(f_pop(1'b0, 1'b1, 1'b0));
        do_reset();
        run_op(f_push(2'b00, 16'h7777, '0, '0));
        run_op(f_pop(1'b1, 1'b0, 1'b0));
        run_op(f_idle());
        #1;
        check_eq("orphan_err", 32'(access_error), 32'd1);
        check_eq("orphan_no_pc", 32'(pc_restore_valid), 32'd0);

        // Multiple pop tags at once.
        do_reset();
        run_op(f_push(2'b00, 16'h0BAD, '0, '0));
        run_op(f_pop(1'b1, 1'b1, 1'b0));
        #1;
        check_eq("multi_err", 32'(access_error), 32'd1);
        run_op(f_idle());

        // Random rounds.
        for (int unsigned rnd = 0; rnd < 3; rnd++) begin
            do_reset();
            for (int unsigned a = 0; a < 16; a++) run_op(f_st(12'(a), 16'($urandom)));
            for (int unsigned n = 0; n < 300; n++) run_op(rnd_op());
            run_op(f_idle());
        end

        // Fill to SP==0, then one more push overflows.
        do_reset();
        for (int unsigned n = 0; n < TOP; n++) run_op(f_push(2'b00, 16'(n), '0, '0));
        #1;
        check_eq("full_sp", 32'(sp), 32'd0);
        run_op(f_push(2'b00, 16'hDEAD, '0, '0));
        #1;
        check_eq("ovf_flag", 32'(stack_overflow), 32'd1);
        check_eq("ovf_sp", 32'(sp), 32'd0);
        run_op(f_pop(1'b0, 1'b0, 1'b0));
        run_op(f_idle());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
